// File: rtl/mc_ctrl_if.sv
// Purpose : bundles the mc_ctrl control-to-datapath signals into one port.
// Latency : none; this is a wiring bundle only.
// Backpressure: Mem_Ready is the only stall input and flows master-ward.
// Ports   : START/OP/Mem_Ready into the controller. PC, IR, memory, register-file
//           and ALU strobes/selects leave it, along with Busy/Halted/Error/Instr_Count.
//           master = controller side, slave = datapath/memory side.
interface mc_ctrl_if;
   logic        START;
   logic [5:0]  OP;
   logic        Mem_Ready;
   logic        PC_Write;
   logic        PC_Write_Cond;
   logic [1:0]  PC_Source;
   logic        I_or_D;
   logic        Mem_Read;
   logic        Mem_Write;
   logic        IR_Write;
   logic        Reg_Dst;
   logic        Mem_to_Reg;
   logic        Reg_Write;
   logic        ALU_Src_A;
   logic [1:0]  ALU_Src_B;
   logic [1:0]  ALU_OP;
   logic        Busy;
   logic        Halted;
   logic [1:0]  Error;
   logic [15:0] Instr_Count;

   modport master (
      input  START, OP, Mem_Ready,
      output PC_Write, PC_Write_Cond, PC_Source, I_or_D, Mem_Read, Mem_Write,
             IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write, ALU_Src_A, ALU_Src_B,
             ALU_OP, Busy, Halted, Error, Instr_Count
   );

   modport slave (
      output START, OP, Mem_Ready,
      input  PC_Write, PC_Write_Cond, PC_Source, I_or_D, Mem_Read, Mem_Write,
             IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write, ALU_Src_A, ALU_Src_B,
             ALU_OP, Busy, Halted, Error, Instr_Count
   );
endinterface

// File: rtl/mc_ctrl.sv
// Purpose : multi-cycle IF/ID/EX/MEM/WB control FSM for the 16-bit CPU over one memory port.
// Latency : R/ADDI/SW 4, LW 5, BEQ/J 3 cycles; +1 per memory wait cycle.
// Backpressure: FETCH/MEM hold all strobes while Mem_Ready=0; MAX_WAIT+1 idle cycles -> ERR.
// Ports   : CLK, RST (async active-high), bus (mc_ctrl_if.master): START, OP, Mem_Ready in;
//           PC/IR/memory/register/ALU controls, Busy, Halted, Error, Instr_Count out.
module mc_ctrl #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        CLK,
   input  logic        RST,
   mc_ctrl_if.master   bus
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR, S_JMP, S_HALT, S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic [1:0]  err_q, err_d;
   logic [15:0] cnt_q, cnt_d;
   logic        retire;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         wait_q  <= 8'd0;
         err_q   <= 2'b00;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Retirement is tagged on the transition out of an instruction's last state.
   assign cnt_d = cnt_q + {15'd0, retire};

   always_comb begin
      state_d           = state_q;
      wait_d            = wait_q;
      err_d             = err_q;
      retire            = 1'b0;
      bus.PC_Write      = 1'b0;
      bus.PC_Write_Cond = 1'b0;
      bus.PC_Source     = 2'b00;
      bus.I_or_D        = 1'b0;
      bus.Mem_Read      = 1'b0;
      bus.Mem_Write     = 1'b0;
      bus.IR_Write      = 1'b0;
      bus.Reg_Dst       = 1'b0;
      bus.Mem_to_Reg    = 1'b0;
      bus.Reg_Write     = 1'b0;
      bus.ALU_Src_A     = 1'b0;
      bus.ALU_Src_B     = 2'b00;
      bus.ALU_OP        = 2'b00;
      bus.Halted        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.START) state_d = S_FETCH;
         end

         S_FETCH: begin
            // ALU computes PC+1 alongside the instruction read.
            bus.Mem_Read  = 1'b1;
            bus.ALU_Src_B = 2'b01;
            if (bus.Mem_Ready) begin
               bus.IR_Write = 1'b1;
               bus.PC_Write = 1'b1;
               wait_d       = 8'd0;
               state_d      = S_DECODE;
            end else if (wait_q == MAX_WAIT_C) begin
               wait_d  = 8'd0;
               err_d   = 2'b10;
               state_d = S_ERR;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end

         S_DECODE: begin
            // Speculatively form the branch target PC+1+imm.
            bus.ALU_Src_B = 2'b10;
            case (bus.OP)
               OP_RTYPE, OP_ADDI, OP_LW, OP_SW: state_d = S_EXEC;
               OP_BEQ:  state_d = S_BR;
               OP_J:    state_d = S_JMP;
               OP_HALT: begin
                  state_d = S_HALT;
                  retire  = 1'b1;
               end
               default: begin
                  state_d = S_ERR;
                  err_d   = 2'b01;
               end
            endcase
         end

         S_EXEC: begin
            bus.ALU_Src_A = 1'b1;
            if (bus.OP == OP_RTYPE) begin
               bus.ALU_Src_B = 2'b00;
               bus.ALU_OP    = 2'b10;
               state_d       = S_WB;
            end else begin
               bus.ALU_Src_B = 2'b10;
               state_d       = (bus.OP == OP_ADDI) ? S_WB : S_MEM;
            end
         end

         S_MEM: begin
            bus.I_or_D = 1'b1;
            if (bus.OP == OP_SW) bus.Mem_Write = 1'b1;
            else                 bus.Mem_Read  = 1'b1;
            if (bus.Mem_Ready) begin
               wait_d = 8'd0;
               if (bus.OP == OP_SW) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_q == MAX_WAIT_C) begin
               wait_d  = 8'd0;
               err_d   = 2'b10;
               state_d = S_ERR;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end

         S_WB: begin
            bus.Reg_Write  = 1'b1;
            bus.Reg_Dst    = (bus.OP == OP_RTYPE);
            bus.Mem_to_Reg = (bus.OP == OP_LW);
            retire         = 1'b1;
            state_d        = S_FETCH;
         end

         S_BR: begin
            bus.ALU_Src_A     = 1'b1;
            bus.ALU_OP        = 2'b01;
            bus.PC_Write_Cond = 1'b1;
            bus.PC_Source     = 2'b01;
            retire            = 1'b1;
            state_d           = S_FETCH;
         end

         S_JMP: begin
            bus.PC_Write  = 1'b1;
            bus.PC_Source = 2'b10;
            retire        = 1'b1;
            state_d       = S_FETCH;
         end

         S_HALT: begin
            bus.Halted = 1'b1;
         end

         S_ERR: begin
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.Busy        = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);
   assign bus.Error       = err_q;
   assign bus.Instr_Count = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Purpose : self-checking bench for mc_ctrl with a responsive memory and per-instruction model.
// Latency : each instruction is run for its modelled cycle count, then the next state is checked.
// Backpressure: memory wait cycles are injected per instruction (random 0..MAX_WAIT).
module tb_mc_ctrl;

   localparam int MW = 4;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_HALT = 6'b111111;
   localparam logic [5:0] LEGAL [6] = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   mc_ctrl_if bus();
   mc_ctrl #(.MAX_WAIT(MW)) dut (.CLK(CLK), .RST(RST), .bus(bus.master));

   int          total = 0;
   int          bad   = 0;
   logic [15:0] exp_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] outs();
      return {bus.PC_Write, bus.PC_Write_Cond, bus.PC_Source, bus.I_or_D, bus.Mem_Read,
              bus.Mem_Write, bus.IR_Write, bus.Reg_Dst, bus.Mem_to_Reg, bus.Reg_Write,
              bus.ALU_Src_A, bus.ALU_Src_B, bus.ALU_OP, bus.Busy, bus.Halted, bus.Error};
   endfunction

   function automatic bit is_legal(input logic [5:0] op);
      return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J) || (op == OP_HALT);
   endfunction

   // Cycle counts with memory always ready.
   function automatic int base_lat(input logic [5:0] op);
      case (op)
         OP_R, OP_ADDI, OP_SW: return 4;
         OP_LW:                return 5;
         OP_BEQ, OP_J:         return 3;
         default:              return 2;
      endcase
   endfunction

   // Resets, holds IDLE one cycle with START low, then starts; returns at posedge+1 of FETCH.
   task automatic do_reset(input string tag);
      @(negedge CLK);
      RST = 1'b1;
      bus.START = 1'b1;
      bus.Mem_Ready = 1'b1;
      bus.OP = 6'($urandom);
      #1;
      check({tag, ":in_reset"}, outs(), 20'h0);
      @(negedge CLK);
      check({tag, ":cnt_reset"}, bus.Instr_Count, 16'd0);
      RST = 1'b0;
      bus.START = 1'b0;
      @(negedge CLK);
      check({tag, ":idle"}, outs(), 20'h0);
      bus.START = 1'b1;
      @(posedge CLK);
      #1;
      exp_cnt = 16'd0;
   endtask

   // Runs one instruction starting at posedge+1 of its FETCH cycle; fw/mw = wait cycles.
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input string tag);
      int lat, remf, remm;
      int n_ir, n_pc, n_rw, n_mr, n_mw, n_pwc, n_sel, n_idle;
      bit memop, lw, sw;
      logic rdy;
      n_ir = 0; n_pc = 0; n_rw = 0; n_mr = 0; n_mw = 0; n_pwc = 0; n_sel = 0; n_idle = 0;
      lw = (op == OP_LW);
      sw = (op == OP_SW);
      memop = lw || sw;
      lat = base_lat(op) + fw + (memop ? mw : 0);
      remf = fw;
      remm = mw;
      bus.OP = op;
      for (int c = 0; c < lat; c++) begin
         bus.START = 1'($urandom_range(0, 1));
         if (bus.Mem_Read || bus.Mem_Write) begin
            if (!bus.I_or_D) begin rdy = (remf == 0); if (remf > 0) remf--; end
            else             begin rdy = (remm == 0); if (remm > 0) remm--; end
         end else begin
            rdy = 1'($urandom_range(0, 1));
         end
         bus.Mem_Ready = rdy;
         @(negedge CLK);
         if (bus.IR_Write) begin
            n_ir++;
            if (!bus.PC_Write || bus.PC_Source != 2'b00) n_sel++;
         end
         if (bus.PC_Write) n_pc++;
         if (bus.PC_Write && !bus.IR_Write && bus.PC_Source != 2'b10) n_sel++;
         if (bus.Mem_Read) n_mr++;
         if (bus.Mem_Write) n_mw++;
         if ((bus.Mem_Read || bus.Mem_Write) && (bus.I_or_D != (c > fw))) n_sel++;
         if (bus.Reg_Write) begin
            n_rw++;
            if (bus.Reg_Dst != (op == OP_R) || bus.Mem_to_Reg != lw) n_sel++;
         end
         if (bus.PC_Write_Cond) begin
            n_pwc++;
            if (bus.PC_Source != 2'b01 || bus.ALU_OP != 2'b01 || !bus.ALU_Src_A) n_sel++;
         end
         if (!bus.Busy) n_idle++;
         @(posedge CLK);
         #1;
      end
      if (is_legal(op)) exp_cnt = exp_cnt + 16'd1;
      check({tag, ":cnt"}, bus.Instr_Count, exp_cnt);
      if (op == OP_HALT)      check({tag, ":halted"}, outs(), 20'h4);
      else if (!is_legal(op)) check({tag, ":illegal"}, outs(), 20'h1);
      else check({tag, ":next_fetch"}, {bus.Mem_Read, bus.I_or_D, bus.ALU_Src_B, bus.Busy}, 5'b1_0_01_1);
      check({tag, ":ir_write"}, n_ir, 1);
      check({tag, ":pc_write"}, n_pc, (op == OP_J) ? 2 : 1);
      check({tag, ":reg_write"}, n_rw, (op == OP_R || op == OP_ADDI || lw) ? 1 : 0);
      check({tag, ":mem_read_cyc"}, n_mr, fw + 1 + (lw ? mw + 1 : 0));
      check({tag, ":mem_write_cyc"}, n_mw, sw ? mw + 1 : 0);
      check({tag, ":pwc"}, n_pwc, (op == OP_BEQ) ? 1 : 0);
      check({tag, ":selects"}, n_sel, 0);
      check({tag, ":busy"}, n_idle, 0);
   endtask

   // Toggles START and Mem_Ready in a terminal state; outputs must not move.
   task automatic poke_terminal(input logic [19:0] want, input string tag);
      for (int i = 0; i < 6; i++) begin
         bus.START = ~bus.START;
         bus.Mem_Ready = 1'($urandom_range(0, 1));
         @(posedge CLK);
         #1;
      end
      check({tag, ":stay"}, outs(), want);
      check({tag, ":stay_cnt"}, bus.Instr_Count, exp_cnt);
   endtask

   initial begin
      int n_ir, n_pc, n_fetch;
      RST = 1'b1;
      bus.START = 1'b0;
      bus.OP = 6'd0;
      bus.Mem_Ready = 1'b0;

      // R-type, J, HALT with memory always ready.
      do_reset("t1");
      run_instr(OP_R, 0, 0, "t1_r");
      run_instr(OP_J, 0, 0, "t1_j");
      run_instr(OP_HALT, 0, 0, "t1_halt");
      check("t1_count3", bus.Instr_Count, 16'd3);
      poke_terminal(20'h4, "t1_halt");

      // LW with 3 memory waits (8 cycles), BEQ, wait boundaries, random program, illegal op.
      do_reset("t2");
      run_instr(OP_LW, 0, 3, "t2_lw_wait3");
      run_instr(OP_BEQ, 0, 0, "t5_beq");
      run_instr(OP_R, MW, 0, "fetch_wait_max");
      run_instr(OP_SW, 0, MW, "sw_wait_max");
      run_instr(OP_LW, MW, MW, "lw_wait_max");
      run_instr(OP_ADDI, 1, 0, "addi");
      for (int i = 0; i < 24; i++) begin
         run_instr(LEGAL[$urandom_range(0, 5)], $urandom_range(0, MW), $urandom_range(0, MW), "rand");
      end
      run_instr(6'b010101, 0, 0, "t4_illegal");
      poke_terminal(20'h1, "t4_err");

      // Memory never ready during FETCH: ERR after MAX_WAIT+1 fetch cycles.
      do_reset("t3");
      n_ir = 0; n_pc = 0; n_fetch = 0;
      for (int c = 0; c < MW + 1; c++) begin
         bus.Mem_Ready = 1'b0;
         bus.START = 1'($urandom_range(0, 1));
         @(negedge CLK);
         if (bus.IR_Write) n_ir++;
         if (bus.PC_Write) n_pc++;
         if (bus.Mem_Read && !bus.I_or_D && bus.Busy) n_fetch++;
         @(posedge CLK);
         #1;
      end
      check("t3_fetch_cycles", n_fetch, MW + 1);
      check("t3_no_ir", n_ir, 0);
      check("t3_no_pc", n_pc, 0);
      check("t3_timeout", outs(), 20'h2);
      poke_terminal(20'h2, "t3_err");

      // Reset in the middle of SW's MEM state, then a clean restart.
      do_reset("t6");
      bus.OP = OP_SW;
      bus.Mem_Ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge CLK);
         #1;
      end
      bus.Mem_Ready = 1'b0;
      @(negedge CLK);
      check("t6_mem_write", {bus.Mem_Write, bus.I_or_D}, 2'b11);
      #1;
      RST = 1'b1;
      #1;
      check("t6_drop", outs(), 20'h0);
      check("t6_cnt", bus.Instr_Count, 16'd0);
      @(negedge CLK);
      RST = 1'b0;
      bus.START = 1'b1;
      bus.Mem_Ready = 1'b1;
      @(posedge CLK);
      #1;
      exp_cnt = 16'd0;
      run_instr(OP_SW, 1, 1, "t6_restart");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the 16-bit CPU datapath: 26-bit instructions, 6-bit opcode in Instr[25:20], 6-bit funct in Instr[5:0], word-addressed PC.
- Replaces the single-cycle Decoder with IF/ID/EX/MEM/WB sequencing over one shared memory port.
- Drives the PC, IR, register file, ALU-source and memory strobes.
- Stalls on a memory ready handshake and flags halt, illegal opcodes and memory timeouts.

Parameters:
- MAX_WAIT, 15: maximum consecutive not-ready cycles tolerated in a memory state before timeout. Legal range 1..255.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  level; starts execution from IDLE.
- OP  in  6  opcode, taken from the IR output (Instr[25:20]).
- Mem_Ready  in  1  memory has completed the current read or write this cycle.
- PC_Write  out  1  unconditional PC load.
- PC_Write_Cond  out  1  PC load qualified by ALU Zero (BEQ).
- PC_Source  out  2  PC mux select: 00 = ALU (PC+1), 01 = branch target register, 10 = jump target Instr[15:0].
- I_or_D  out  1  memory address select: 0 = PC, 1 = ALU result register.
- Mem_Read  out  1  memory read request.
- Mem_Write  out  1  memory write request.
- IR_Write  out  1  instruction register load.
- Reg_Dst  out  1  register write address select: 0 = rt, 1 = rd.
- Mem_to_Reg  out  1  register write data select: 0 = ALU result, 1 = MDR.
- Reg_Write  out  1  register file write enable.
- ALU_Src_A  out  1  ALU A select: 0 = PC, 1 = rs data.
- ALU_Src_B  out  2  ALU B select: 00 = rt data, 01 = constant 1, 10 = sign-extended immediate.
- ALU_OP  out  2  to ALU_ctrl: 00 = add, 01 = sub, 10 = use funct.
- Busy  out  1  FSM is not in IDLE, HALT or ERR.
- Halted  out  1  FSM is in HALT.
- Error  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout. Sticky until RST.
- Instr_Count  out  16  count of retired instructions; wraps 0xFFFF to 0x0000.

Behaviour:
- Reset (asynchronous): state = IDLE, Instr_Count = 0, Error = 00, wait counter = 0. Every strobe is 0 and every select is 0 while in reset.
- Default outputs: all 0 unless a state listed below drives them.
- Opcodes:
  - R-type = 000000
  - ADDI = 001000
  - LW = 100011
  - SW = 101011
  - BEQ = 000100
  - J = 000010
  - HALT = 111111
  - Any other value is illegal.
- IDLE: when START = 1, go to FETCH on the next edge; otherwise stay.
- FETCH:
  - Drives Mem_Read = 1, I_or_D = 0, ALU_Src_A = 0, ALU_Src_B = 01, ALU_OP = 00, PC_Source = 00.
  - IR_Write and PC_Write assert in the same cycle only when Mem_Ready = 1; the FSM then moves to DECODE.
  - If Mem_Ready = 0, the FSM holds all outputs and stays in FETCH.
- DECODE:
  - Drives ALU_Src_A = 0, ALU_Src_B = 10, ALU_OP = 00 (branch target = PC+1+imm).
  - Next state by opcode: R-type/ADDI/LW/SW go to EXEC; BEQ goes to BR; J goes to JMP; HALT goes to HALT; illegal goes to ERR with Error = 01.
- EXEC:
  - R-type: ALU_Src_A = 1, ALU_Src_B = 00, ALU_OP = 10, then WB.
  - ADDI/LW/SW: ALU_Src_A = 1, ALU_Src_B = 10, ALU_OP = 00. ADDI goes to WB; LW and SW go to MEM.
- MEM:
  - Drives I_or_D = 1 plus Mem_Read (LW) or Mem_Write (SW), held until Mem_Ready = 1.
  - LW with Mem_Ready = 1 goes to WB. SW with Mem_Ready = 1 retires and goes to FETCH.
- WB:
  - Reg_Write = 1.
  - R-type: Reg_Dst = 1, Mem_to_Reg = 0. ADDI: Reg_Dst = 0, Mem_to_Reg = 0. LW: Reg_Dst = 0, Mem_to_Reg = 1.
  - Retires, then goes to FETCH.
- BR: ALU_Src_A = 1, ALU_Src_B = 00, ALU_OP = 01, PC_Write_Cond = 1, PC_Source = 01. Retires, then FETCH.
- JMP: PC_Write = 1, PC_Source = 10. Retires, then FETCH.
- HALT: Halted = 1; the HALT instruction itself retires. Only RST exits HALT.
- ERR: terminal state; only RST exits.
- Retire: Instr_Count increments by 1 on the edge that leaves the instruction's last state.
- Latency with Mem_Ready tied to 1: R-type 4 cycles, ADDI 4, LW 5, SW 4, BEQ 3, J 3.
- Each wait cycle in FETCH or MEM adds exactly 1 cycle.
- Timeout:
  - The wait counter increments on each cycle spent in FETCH or MEM with Mem_Ready = 0, and clears on Mem_Ready = 1 or on leaving the state.
  - When the counter equals MAX_WAIT and Mem_Ready is still 0, the FSM goes to ERR with Error = 10.
  - Mem_Ready arriving in that same cycle wins: normal progress, no error.
- START is ignored outside IDLE. Deasserting START mid-instruction has no effect.
- RST asserted mid-instruction: immediate return to IDLE and all strobes drop in the same cycle (no partial write completes after reset).
- Mem_Ready outside FETCH and MEM is ignored.

Test Plan:
1. RST, then START = 1, Mem_Ready = 1, program R-type then J then HALT -> state sequences FETCH-DECODE-EXEC-WB and FETCH-DECODE-JMP; Instr_Count = 3 at HALT; Halted = 1; Busy = 0.
2. LW with Mem_Ready low for 3 cycles in MEM -> LW takes 8 cycles; Mem_Read and I_or_D = 1 held throughout; exactly one Reg_Write pulse with Mem_to_Reg = 1, Reg_Dst = 0.
3. MAX_WAIT = 4, Mem_Ready stuck at 0 in FETCH -> ERR entered after 5 FETCH cycles; Error = 10; IR_Write and PC_Write never asserted.
4. OP = 010101 at DECODE -> ERR with Error = 01; Instr_Count unchanged; START toggling afterwards has no effect.
5. BEQ -> BR asserts PC_Write_Cond = 1, PC_Source = 01, ALU_OP = 01 for exactly one cycle; 3-cycle latency.
6. RST pulse during MEM of SW -> Mem_Write drops in the same cycle; state = IDLE, Instr_Count = 0; a new START re-fetches normally.
